// File: rtl/div_pkg.sv
// Shared types and constants for the pipe_div iterative divider.
package div_pkg;

  localparam int unsigned DIV_XLEN = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  // Iteration counter width; a single-iteration build still needs one bit.
  function automatic int unsigned div_cnt_w(input int unsigned iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract divisor.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_sub;
  logic            w_ok;

  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_ok    = (w_shift >= {1'b0, i_divisor});
  // When the trial succeeds the difference is below the divisor, so XLEN bits suffice.
  assign w_sub   = w_shift[XLEN-1:0] - i_divisor;
  assign o_rem   = w_ok ? w_sub : w_shift[XLEN-1:0];
  assign o_quo   = {i_quo[XLEN-2:0], w_ok};

endmodule

// File: rtl/pipe_div.sv
// Fixed-latency iterative restoring divider with start/done handshake.
// Optional signed operation is enabled by defining DIV_SIGNED_EN.
module pipe_div
  import div_pkg::*;
#(
  parameter int unsigned XLEN           = DIV_XLEN,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic            signed_op,
`endif
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            busy,
  output logic            done
);

  localparam int unsigned ITER  = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = div_cnt_w(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  div_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_rem, r_quo, r_dvs, r_q, r_r;
  logic [XLEN-1:0] w_a, w_b, w_q_fin, w_r_fin;
  logic            w_accept;
  logic [XLEN-1:0] w_rem [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] w_quo [BITS_PER_CYCLE+1];

  assign w_accept = start && ((r_state == IDLE) || (r_state == FIN));
  assign w_rem[0] = r_rem;
  assign w_quo[0] = r_quo;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .i_rem     (w_rem[gi]),
      .i_quo     (w_quo[gi]),
      .i_divisor (r_dvs),
      .o_rem     (w_rem[gi+1]),
      .o_quo     (w_quo[gi+1])
    );
  end

`ifdef DIV_SIGNED_EN
  logic w_sa, w_sb, r_neg_q, r_neg_r;

  assign w_sa = signed_op & dividend[XLEN-1];
  assign w_sb = signed_op & divisor[XLEN-1];
  assign w_a  = w_sa ? ('0 - dividend) : dividend;
  assign w_b  = w_sb ? ('0 - divisor)  : divisor;
  assign w_q_fin = r_neg_q ? ('0 - w_quo[BITS_PER_CYCLE]) : w_quo[BITS_PER_CYCLE];
  assign w_r_fin = r_neg_r ? ('0 - w_rem[BITS_PER_CYCLE]) : w_rem[BITS_PER_CYCLE];

  // Zero divisor keeps the all-ones quotient unnegated so it reads as -1;
  // most-negative / -1 falls out of the magnitude core with no special case.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= (w_sa ^ w_sb) & (divisor != '0);
      r_neg_r <= w_sa;
    end
  end
`else
  assign w_a     = dividend;
  assign w_b     = divisor;
  assign w_q_fin = w_quo[BITS_PER_CYCLE];
  assign w_r_fin = w_rem[BITS_PER_CYCLE];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_q     <= '0;
      r_r     <= '0;
    end else if (w_accept) begin
      r_state <= CALC;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= w_a;
      r_dvs   <= w_b;
    end else begin
      case (r_state)
        CALC: begin
          r_rem <= w_rem[BITS_PER_CYCLE];
          r_quo <= w_quo[BITS_PER_CYCLE];
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= FIN;
            r_q     <= w_q_fin;
            r_r     <= w_r_fin;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign quotient  = r_q;
  assign remainder = r_r;
  assign busy      = (r_state == CALC);
  assign done      = (r_state == FIN);

endmodule

// File: tb/tb_pipe_div.sv
// Self-checking bench for pipe_div across BITS_PER_CYCLE = 1,2,4,8 (instances 0..3).
module tb_pipe_div;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a [4];
  logic [63:0] a_a     [4];
  logic [63:0] b_a     [4];
  logic        sg_a    [4];
  logic [63:0] q_a     [4];
  logic [63:0] r_a     [4];
  logic        busy_a  [4];
  logic        done_a  [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    pipe_div #(.XLEN(64), .BITS_PER_CYCLE(1 << g)) u_dut (
      .clock     (clk),
      .reset     (rst),
      .start     (start_a[g]),
      .dividend  (a_a[g]),
      .divisor   (b_a[g]),
`ifdef DIV_SIGNED_EN
      .signed_op (sg_a[g]),
`endif
      .quotient  (q_a[g]),
      .remainder (r_a[g]),
      .busy      (busy_a[g]),
      .done      (done_a[g])
    );
  end

  int checks = 0;
  int errors = 0;
  logic [63:0] qexp[$];
  logic [63:0] rexp[$];

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic [63:0] q;
    logic [63:0] r;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic s,
                       output logic [63:0] q, output logic [63:0] r);
    if (b == 64'd0) begin
      q = '1;
      r = a;
    end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a;
      r = '0;
    end else if (s) begin
      q = 64'($signed(a) / $signed(b));
      r = 64'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Drive a start for one cycle and queue its expected result.
  task automatic issue(input int k, input logic [63:0] a, input logic [63:0] b, input logic s,
                       input logic [63:0] eq, input logic [63:0] er);
    start_a[k] = 1'b1;
    a_a[k] = a;
    b_a[k] = b;
    sg_a[k] = s;
    qexp.push_back(eq);
    rexp.push_back(er);
  endtask

  // Count negedges until done; optionally pokes a rogue start at cycle 'poke'.
  task automatic wait_done(input int k, input int poke, output int lat, output int bc);
    lat = 0;
    bc = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (busy_a[k]) bc++;
      if (done_a[k] || lat > 300) break;
      start_a[k] = 1'b0;
      if (lat == poke) begin
        start_a[k] = 1'b1;
        a_a[k] = 64'd1000;
        b_a[k] = 64'd3;
      end
    end
  endtask

  task automatic pop_chk(input int k, input string nm);
    logic [63:0] eq, er;
    if (qexp.size() == 0) begin
      chk({nm, "_queue"}, 64'd0, 64'd1);
    end else begin
      eq = qexp.pop_front();
      er = rexp.pop_front();
      chk({nm, "_q"}, q_a[k], eq);
      chk({nm, "_r"}, r_a[k], er);
    end
  endtask

  task automatic do_op(input int k, input logic [63:0] a, input logic [63:0] b, input logic s,
                       input logic [63:0] eq, input logic [63:0] er, input string nm);
    int lat, bc;
    issue(k, a, b, s, eq, er);
    wait_done(k, -1, lat, bc);
    chk({nm, "_lat"}, 64'(lat), 64'((64 >> k) + 1));
    chk({nm, "_busy"}, 64'(bc), 64'(64 >> k));
    pop_chk(k, nm);
    @(negedge clk);
    chk({nm, "_pulse"}, {63'd0, done_a[k]}, 64'd0);
  endtask

  vec_t tbl[$];

  initial begin
    int lat, bc, cnt;
    logic [63:0] a, b, eq, er;
    logic s;

    for (int i = 0; i < 4; i++) begin
      start_a[i] = 1'b0;
      a_a[i] = '0;
      b_a[i] = '0;
      sg_a[i] = 1'b0;
    end

    tbl.push_back('{64'd100, 64'd7, 1'b0, 64'd14, 64'd2});
    tbl.push_back('{'1, 64'd0, 1'b0, '1, '1});
    tbl.push_back('{64'd12345, 64'd1, 1'b0, 64'd12345, 64'd0});
    tbl.push_back('{64'd9, 64'd10, 1'b0, 64'd0, 64'd9});
    tbl.push_back('{64'd1, '1, 1'b0, 64'd0, 64'd1});
    tbl.push_back('{'1, '1, 1'b0, 64'd1, 64'd0});
    tbl.push_back('{64'h8000_0000_0000_0000, 64'd3, 1'b0, 64'd3074457345618258602, 64'd2});
`ifdef DIV_SIGNED_EN
    tbl.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, '1});
    tbl.push_back('{64'h8000_0000_0000_0000, '1, 1'b1, 64'h8000_0000_0000_0000, 64'd0});
    tbl.push_back('{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1});
    tbl.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b1, '1, 64'hFFFF_FFFF_FFFF_FFF9});
`endif

    repeat (3) @(negedge clk);
    chk("reset_q", q_a[0], 64'd0);
    chk("reset_r", r_a[0], 64'd0);
    chk("reset_busy_done", {62'd0, busy_a[0], done_a[0]}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i])
      do_op(0, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].q, tbl[i].r, $sformatf("vec%0d", i));

    // Back-to-back: second start issued while the first is in FIN.
    issue(0, 64'd12345, 64'd1, 1'b0, 64'd12345, 64'd0);
    wait_done(0, -1, lat, bc);
    chk("b2b1_lat", 64'(lat), 64'd65);
    pop_chk(0, "b2b1");
    issue(0, 64'd9, 64'd10, 1'b0, 64'd0, 64'd9);
    wait_done(0, -1, lat, bc);
    chk("b2b2_lat", 64'(lat), 64'd65);
    chk("b2b2_busy", 64'(bc), 64'd64);
    pop_chk(0, "b2b2");

    // Start pulsed mid-CALC must be ignored.
    @(negedge clk);
    issue(0, 64'd100, 64'd7, 1'b0, 64'd14, 64'd2);
    wait_done(0, 10, lat, bc);
    chk("poke_lat", 64'(lat), 64'd65);
    pop_chk(0, "poke");
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_a[0]) cnt++;
    end
    chk("poke_extra_done", 64'(cnt), 64'd0);

    // Reset during CALC aborts the operation and clears outputs.
    start_a[0] = 1'b1;
    a_a[0] = 64'd77;
    b_a[0] = 64'd3;
    @(negedge clk);
    start_a[0] = 1'b0;
    repeat (19) @(negedge clk);
    chk("abort_busy_before", {63'd0, busy_a[0]}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_q", q_a[0], 64'd0);
    chk("abort_busy_done", {62'd0, busy_a[0], done_a[0]}, 64'd0);
    rst = 1'b0;
    cnt = 0;
    repeat (70) begin
      @(negedge clk);
      if (done_a[0]) cnt++;
    end
    chk("abort_no_done", 64'(cnt), 64'd0);
    do_op(0, 64'd50, 64'd5, 1'b0, 64'd10, 64'd0, "after_abort");

    // Random operands on every BITS_PER_CYCLE variant.
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 6; n++) begin
        a = {$urandom, $urandom};
        case (n % 3)
          0: b = {$urandom, $urandom};
          1: b = 64'($urandom_range(1, 1000));
          default: b = {32'd0, $urandom};
        endcase
        if (n == 5) b = 64'd0;
`ifdef DIV_SIGNED_EN
        s = $urandom_range(0, 1) == 1;
`else
        s = 1'b0;
`endif
        model(a, b, s, eq, er);
        do_op(k, a, b, s, eq, er, $sformatf("rnd_k%0d_n%0d", k, n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
